// File: rtl/tpu_pkg.sv
// tpu_pkg: shared constants, derived counter widths, FSM state encoding and the
// operand zero-extension helper for the TinyTPU host-side stream driver.
//   D_W  : operand width in bits
//   N    : systolic array dimension (N pairs per load, N*N results per run)
//   WORD : serial word length per operand (WORD >= D_W)
package tpu_pkg;
   localparam int D_W    = 8;
   localparam int N      = 2;
   localparam int WORD   = 8;

   localparam int RES_W  = 2 * D_W;      // deserialized result width
   localparam int FIFO_W = RES_W + 1;    // result data + last flag
   localparam int FIFO_D = N * N;        // one full computation of results

   localparam int PAIR_CW = $clog2(N + 1);
   localparam int LBIT_CW = $clog2(WORD + 1);
   localparam int RBIT_CW = $clog2(RES_W + 1);
   localparam int RES_CW  = $clog2(N * N + 1);

   localparam logic [PAIR_CW-1:0] N_PAIRS   = PAIR_CW'(N);
   localparam logic [LBIT_CW-1:0] WORD_LAST = LBIT_CW'(WORD - 1);
   localparam logic [RBIT_CW-1:0] RBIT_LAST = RBIT_CW'(RES_W - 1);
   localparam logic [RES_CW-1:0]  RES_LAST  = RES_CW'(N * N - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      START,
      COLLECT
   } state_t;

   function automatic logic [WORD-1:0] zext_operand(input logic [D_W-1:0] v);
      return WORD'(v);
   endfunction
endpackage

// File: rtl/tpu_stream_driver_if.sv
// tpu_stream_driver_if: bundles the operand stream (s_*), the bit-serial core
// link (data_in_x/y, load_en, init, data_out_z, tx_ready), the result stream
// (m_*) and the busy flag.
//   master : host/core side (drives s_valid/s_x/s_y, data_out_z, tx_ready, m_ready)
//   slave  : the stream driver itself
interface tpu_stream_driver_if;
   import tpu_pkg::*;

   logic             s_valid;
   logic             s_ready;
   logic [D_W-1:0]   s_x;
   logic [D_W-1:0]   s_y;
   logic             data_in_x;
   logic             data_in_y;
   logic             load_en;
   logic             init;
   logic             data_out_z;
   logic             tx_ready;
   logic             m_valid;
   logic             m_ready;
   logic [RES_W-1:0] m_data;
   logic             m_last;
   logic             busy;

   modport master (
      output s_valid, s_x, s_y, data_out_z, tx_ready, m_ready,
      input  s_ready, data_in_x, data_in_y, load_en, init,
             m_valid, m_data, m_last, busy
   );

   modport slave (
      input  s_valid, s_x, s_y, data_out_z, tx_ready, m_ready,
      output s_ready, data_in_x, data_in_y, load_en, init,
             m_valid, m_data, m_last, busy
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush on rst.
//   clk, rst : clock, synchronous active-high flush
//   push/din : write request and data (ignored when full unless popping)
//   pop      : read request (ignored when empty)
//   dout     : head entry, forced to zero while empty
//   empty    : no entries held
module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   // Zero while empty so the result bus reads 0 out of reset and between bursts.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/tpu_stream_driver.sv
// tpu_stream_driver: host front end for the TinyTPU systolic core.
// Serializes N operand pairs MSB-first onto data_in_x/y under load_en, pulses
// init, then deserializes N*N results of 2*D_W bits from data_out_z (qualified
// by tx_ready) into a result FIFO drained through the m_* stream.
//   clk, rst : clock, synchronous active-high reset
//   bus      : tpu_stream_driver_if.slave (operand stream, core link, result
//              stream, busy)
// Every output is a register or a decode of registers only.
module tpu_stream_driver
   import tpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   tpu_stream_driver_if.slave bus
);
   state_t             state, state_n;
   logic [PAIR_CW-1:0] pair_cnt, pair_cnt_n;
   logic [LBIT_CW-1:0] lbits_left, lbits_left_n;
   logic [RBIT_CW-1:0] rbit_cnt, rbit_cnt_n;
   logic [RES_CW-1:0]  res_cnt, res_cnt_n;
   logic [WORD-1:0]    x_sh, x_sh_n, y_sh, y_sh_n;
   logic [RES_W-2:0]   z_sh, z_sh_n;
   logic               s_ready_q, s_ready_n;
   logic               data_x_q, data_x_n;
   logic               data_y_q, data_y_n;
   logic               load_en_q, load_en_n;
   logic               init_q, init_n;
   logic               busy_q, busy_n;

   logic               accept;
   logic               start_word;
   logic               push, push_last, pop;
   logic               fifo_empty;
   logic [RES_W-1:0]   push_word;
   logic [FIFO_W-1:0]  fifo_dout;
   logic [WORD-1:0]    x_ext, y_ext;

   assign accept    = bus.s_valid && s_ready_q;
   assign x_ext     = zext_operand(bus.s_x);
   assign y_ext     = zext_operand(bus.s_y);
   assign pop       = !fifo_empty && bus.m_ready;
   assign push_word = {z_sh, bus.data_out_z};

   always_comb begin
      state_n      = state;
      pair_cnt_n   = pair_cnt;
      lbits_left_n = lbits_left;
      rbit_cnt_n   = rbit_cnt;
      res_cnt_n    = res_cnt;
      x_sh_n       = x_sh;
      y_sh_n       = y_sh;
      z_sh_n       = z_sh;
      data_x_n     = data_x_q;
      data_y_n     = data_y_q;
      load_en_n    = load_en_q;
      init_n       = 1'b0;
      start_word   = 1'b0;
      push         = 1'b0;
      push_last    = 1'b0;

      case (state)
         IDLE: begin
            if (accept) begin
               state_n    = LOAD;
               start_word = 1'b1;
            end
         end
         LOAD: begin
            if (lbits_left != '0) begin
               data_x_n     = x_sh[WORD-1];
               data_y_n     = y_sh[WORD-1];
               x_sh_n       = x_sh << 1;
               y_sh_n       = y_sh << 1;
               lbits_left_n = lbits_left - 1'b1;
            end else if (accept) begin
               start_word = 1'b1;
            end else begin
               // Word boundary with nothing to send: idle the serial link.
               load_en_n = 1'b0;
               data_x_n  = 1'b0;
               data_y_n  = 1'b0;
               if (pair_cnt == N_PAIRS) begin
                  state_n = START;
                  init_n  = 1'b1;
               end
            end
         end
         START: begin
            state_n = COLLECT;
         end
         COLLECT: begin
            if (bus.tx_ready) begin
               z_sh_n = push_word[RES_W-2:0];
               if (rbit_cnt == RBIT_LAST) begin
                  push       = 1'b1;
                  push_last  = (res_cnt == RES_LAST);
                  rbit_cnt_n = '0;
                  if (res_cnt == RES_LAST) begin
                     state_n    = IDLE;
                     res_cnt_n  = '0;
                     pair_cnt_n = '0;
                  end else begin
                     res_cnt_n = res_cnt + 1'b1;
                  end
               end else begin
                  rbit_cnt_n = rbit_cnt + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Accepting a pair drives its MSB out on the very next cycle.
      if (start_word) begin
         data_x_n     = x_ext[WORD-1];
         data_y_n     = y_ext[WORD-1];
         x_sh_n       = x_ext << 1;
         y_sh_n       = y_ext << 1;
         lbits_left_n = WORD_LAST;
         load_en_n    = 1'b1;
         pair_cnt_n   = pair_cnt + 1'b1;
      end

      // s_ready is registered, so it is decided from the upcoming state: in
      // LOAD it is raised for the cycle that shows the LSB, which lets the
      // next pair's MSB follow with no gap in load_en.
      s_ready_n = 1'b0;
      if (state_n == IDLE) begin
         s_ready_n = fifo_empty && !push;
      end else if (state_n == LOAD) begin
         s_ready_n = (lbits_left_n == '0) && (pair_cnt_n < N_PAIRS);
      end
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pair_cnt   <= '0;
         lbits_left <= '0;
         rbit_cnt   <= '0;
         res_cnt    <= '0;
         s_ready_q  <= 1'b0;
         data_x_q   <= 1'b0;
         data_y_q   <= 1'b0;
         load_en_q  <= 1'b0;
         init_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state      <= state_n;
         pair_cnt   <= pair_cnt_n;
         lbits_left <= lbits_left_n;
         rbit_cnt   <= rbit_cnt_n;
         res_cnt    <= res_cnt_n;
         s_ready_q  <= s_ready_n;
         data_x_q   <= data_x_n;
         data_y_q   <= data_y_n;
         load_en_q  <= load_en_n;
         init_q     <= init_n;
         busy_q     <= busy_n;
      end
   end

   // Shift registers carry data only; stale contents are overwritten before use.
   always_ff @(posedge clk) begin
      x_sh <= x_sh_n;
      y_sh <= y_sh_n;
      z_sh <= z_sh_n;
   end

   sync_fifo #(
      .W     (FIFO_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({push_last, push_word}),
      .pop   (pop),
      .dout  (fifo_dout),
      .empty (fifo_empty)
   );

   assign bus.s_ready   = s_ready_q;
   assign bus.data_in_x = data_x_q;
   assign bus.data_in_y = data_y_q;
   assign bus.load_en   = load_en_q;
   assign bus.init      = init_q;
   assign bus.busy      = busy_q;
   assign bus.m_valid   = !fifo_empty;
   assign bus.m_data    = fifo_dout[RES_W-1:0];
   assign bus.m_last    = fifo_dout[RES_W];
endmodule
